// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic unit and its arbiter: opcodes and default width.
package logic_unit_pkg;

  localparam int unsigned DATA_W_DEF = 3;

  typedef logic [1:0] op_t;

  localparam op_t OP_OR  = 2'd0;
  localparam op_t OP_AND = 2'd1;
  localparam op_t OP_XOR = 2'd2;
  localparam op_t OP_CAT = 2'd3;

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Requester/consumer bundle of logic_unit_arbiter.
// master: operand sources and result consumer; slave: the arbiter.
interface logic_unit_arbiter_if
  import logic_unit_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic                  req0;
  op_t                   op0;
  logic [DATA_W-1:0]     a0;
  logic [DATA_W-1:0]     b0;
  logic                  gnt0;

  logic                  req1;
  op_t                   op1;
  logic [DATA_W-1:0]     a1;
  logic [DATA_W-1:0]     b1;
  logic                  gnt1;

  logic                  out_valid;
  logic                  out_id;
  logic [2*DATA_W-1:0]   out_data;
  logic                  out_ready;

  modport master (
    output req0, op0, a0, b0,
    output req1, op1, a1, b1,
    output out_ready,
    input  gnt0, gnt1, out_valid, out_id, out_data
  );

  modport slave (
    input  req0, op0, a0, b0,
    input  req1, op1, a1, b1,
    input  out_ready,
    output gnt0, gnt1, out_valid, out_id, out_data
  );

endinterface

// File: rtl/logic_unit.sv
// Combinational logic unit: OR / AND / XOR zero-extended, or {a,b} concatenation.
module logic_unit
  import logic_unit_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  op_t                 op,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [2*DATA_W-1:0] y_c
);

  localparam int unsigned RES_W = 2 * DATA_W;

  // Opcode decode
  always_comb begin
    y_c = '0;
    case (op)
      OP_OR:   y_c = RES_W'(a | b);
      OP_AND:  y_c = RES_W'(a & b);
      OP_XOR:  y_c = RES_W'(a ^ b);
      OP_CAT:  y_c = {a, b};
      default: y_c = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic unit between two requesters, with a
// single-entry valid/ready output register tagged by requester ID.
// Optional feature: define LU_ARB_STATS_EN to add saturating 8-bit grant
// counters gnt_cnt0 / gnt_cnt1.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  logic_unit_arbiter_if.slave  bus
`ifdef LU_ARB_STATS_EN
  ,
  output logic [7:0]           gnt_cnt0,
  output logic [7:0]           gnt_cnt1
`endif
);

  localparam int unsigned RES_W = 2 * DATA_W;

  logic              accept_c;
  logic              gnt0_c;
  logic              gnt1_c;
  op_t               win_op_c;
  logic [DATA_W-1:0] win_a_c;
  logic [DATA_W-1:0] win_b_c;
  logic [RES_W-1:0]  lu_res_c;

  logic              out_valid_q, out_valid_d;
  logic              out_id_q,    out_id_d;
  logic [RES_W-1:0]  out_data_q,  out_data_d;
  logic              last_gnt_q,  last_gnt_d;

  // Grant decision: only when the output can take a result; ties go to the
  // requester not granted last. Reset suppresses grants.
  always_comb begin
    accept_c = !out_valid_q || bus.out_ready;
    gnt0_c   = 1'b0;
    gnt1_c   = 1'b0;
    if (!rst && accept_c) begin
      if (bus.req0 && bus.req1) begin
        gnt0_c = last_gnt_q;
        gnt1_c = !last_gnt_q;
      end else begin
        gnt0_c = bus.req0;
        gnt1_c = bus.req1;
      end
    end
  end

  // Winner operand mux feeding the shared logic unit
  always_comb begin
    win_op_c = gnt1_c ? bus.op1 : bus.op0;
    win_a_c  = gnt1_c ? bus.a1  : bus.a0;
    win_b_c  = gnt1_c ? bus.b1  : bus.b0;
  end

  logic_unit #(.DATA_W(DATA_W)) u_lu (
    .op  (win_op_c),
    .a   (win_a_c),
    .b   (win_b_c),
    .y_c (lu_res_c)
  );

  // Output stage next state: load on grant, drain on pop, otherwise hold
  always_comb begin
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_data_d  = out_data_q;
    last_gnt_d  = last_gnt_q;
    if (gnt0_c || gnt1_c) begin
      out_valid_d = 1'b1;
      out_id_d    = gnt1_c;
      out_data_d  = lu_res_c;
      last_gnt_d  = gnt1_c;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output stage and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
      out_data_q  <= '0;
      last_gnt_q  <= 1'b1;
    end else begin
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_data_q  <= out_data_d;
      last_gnt_q  <= last_gnt_d;
    end
  end

  assign bus.gnt0      = gnt0_c;
  assign bus.gnt1      = gnt1_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_data  = out_data_q;

`ifdef LU_ARB_STATS_EN
  localparam int unsigned CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Saturating grant counters
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (gnt0_c && (cnt0_q != CNT_MAX)) cnt0_d = cnt0_q + CNT_W'(1);
    if (gnt1_c && (cnt1_q != CNT_MAX)) cnt1_d = cnt1_q + CNT_W'(1);
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Shares one 3-bit logic unit (OR / AND / XOR / concatenate) between two requesters. Each requester presents an opcode and two 3-bit operands. A round-robin arbiter grants one requester per cycle. The result is held in a single-entry registered output stage with valid/ready backpressure, tagged with the winning requester's ID. The block sits between the operand sources and the display/consumer logic that drives the marquee-style output.

## Interface
Parameters:
- `DATA_W`, default 3: operand width; result width is 2*DATA_W.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req0` input 1: requester 0 has an operation pending.
- `op0` input 2: requester 0 opcode.
- `a0` input DATA_W: requester 0 operand A.
- `b0` input DATA_W: requester 0 operand B.
- `gnt0` output 1: requester 0 accepted this cycle.
- `req1`, `op1`, `a1`, `b1`, `gnt1`: same as above, for requester 1.
- `out_valid` output 1: `out_data` and `out_id` hold a result.
- `out_id` output 1: requester that issued the current result.
- `out_data` output 2*DATA_W: result.
- `out_ready` input 1: consumer accepts the result this cycle.

## Operation
- Opcodes:
  - 0: OR, A|B, zero-extended to 2*DATA_W.
  - 1: AND, A&B, zero-extended.
  - 2: XOR, A^B, zero-extended.
  - 3: CAT, {A,B}; A occupies the upper half.
- Requester rule: once `req` rises, it stays high with `op`, `a` and `b` stable until `gnt` is seen. Verification checks this as an assumption on the stimulus.
- Accept condition: `accept = !out_valid || out_ready`. No grant is issued while the output is full and stalled.
- Arbitration (only when `accept` is true):
  - One requester active: that requester is granted.
  - Both active: the requester not granted last is granted.
  - `last_gnt` pointer updates only on a grant. Reset value is 1, so requester 0 wins the first tie.
- `gnt0`/`gnt1` are combinational from `req*`, `out_valid`, `out_ready` and `last_gnt`. At most one is high per cycle.
- On a grant, the output register loads the logic-unit result of the winner and `out_id`, and `out_valid` is set to 1.
- No grant, with `out_ready` high and `out_valid` high: `out_valid` clears.
- No grant, with `out_valid` low or `out_ready` low: the register holds.

## Timing
- Reset values: `out_valid`=0, `out_id`=0, `out_data`=0, `last_gnt`=1. `gnt0`/`gnt1` are 0 while `rst` is high.
- Latency: a request granted in cycle N produces its result with `out_valid` high in cycle N+1.
- Throughput: one result per cycle while `out_ready` stays high. With both requesters continuously active, grants alternate 0,1,0,1…
- Stall: while `out_valid` is high and `out_ready` is low, `out_data` and `out_id` hold and no `gnt` is issued.
- Simultaneous pop and grant (`out_valid`, `out_ready` and `req` all high): the new result replaces the old one in the same edge, with no bubble.
- Reset mid-operation: any pending result is dropped. Grants issued in the reset cycle are suppressed, and requesters keep `req` asserted.

## Configuration
- `LU_ARB_STATS_EN` defined: adds outputs `gnt_cnt0` and `gnt_cnt1`, each 8 bits.
  - Each counts grants to its requester.
  - Saturates at 255.
  - Cleared by `rst`.
- `LU_ARB_STATS_EN` not defined: these ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package `logic_unit_pkg`:
  - Opcode constants `OP_OR`=0, `OP_AND`=1, `OP_XOR`=2, `OP_CAT`=3.
  - Opcode typedef (2 bits).
  - Default `DATA_W`.
- Sub-module `logic_unit`: purely combinational `op`/`a`/`b` → 2*DATA_W result, instantiated once on the muxed winner operands.
- The arbiter pointer, output register and optional counters stay in the top module.

## Test plan
- Single request: reset, then `req0`=1, `op0`=3, `a0`=5, `b0`=2 → `gnt0` in cycle N; next cycle `out_valid`=1, `out_id`=0, `out_data`=0x2A.
- Opcode sweep: `a0`=6, `b0`=3 with op 0/1/2 → `out_data`=7, 2, 5, each zero-extended.
- Fairness: `req0` and `req1` held high, `out_ready`=1 for 6 cycles → grant order 0,1,0,1,0,1, one result per cycle.
- Backpressure: `out_valid`=1 and `out_ready`=0 for 3 cycles with `req1` high → no `gnt1`, `out_data` stable. When `out_ready` rises, `gnt1` is issued in that same cycle and the new result appears the next cycle.
- Reset mid-stream: assert `rst` while `out_valid`=1 → next cycle `out_valid`=0, `out_data`=0, `last_gnt`=1, so requester 0 wins the next tie.
- Stats (`LU_ARB_STATS_EN` defined): 300 grants to requester 0 → `gnt_cnt0`=255, `gnt_cnt1`=0.
